enemy_hit_resolver: RTL
=======================

Name: enemy_hit_resolver

Overview:
- Sits directly downstream of the enemy fleet renderer; consumes its per-pixel enemy_on plus the player missile's missile_on during the VGA scan.
- On overlap, resolves which of the 21 fleet enemies (3 rows x 7 columns) was struck from DrawX/DrawY and the fleet origin, using a sequential subtract-divider.
- Maintains the alive mask, issues a one-cycle kill/hit event, and accumulates score. At most one kill per frame.

Parameters:
- COL_PITCH, 73, horizontal spacing between enemy columns (px).
- ROW_PITCH, 50, vertical spacing between enemy rows (px).
- ENEMY_W, 48, sprite width (px); the remainder of the x-division must be below this.
- ENEMY_H, 32, sprite height (px); the remainder of the y-division must be below this.
- PTS_ROW0, 10, points for row 0 (easy); PTS_ROW1 20; PTS_ROW2 30.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame strobe, sampled in the Clk domain
- new_wave  in  1  one-cycle pulse: reload the alive mask to all ones
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- enemy_on  in  1  fleet pixel active
- missile_on  in  1  missile pixel active
- fleet_x  in  10  fleet left edge
- fleet_y  in  10  fleet top edge
- alive_mask  out  21  bit index = row*7+col; 1 = alive
- hit_pulse  out  1  one-cycle kill event
- hit_index  out  5  index of the last kill
- missile_kill  out  1  one-cycle pulse telling the missile to despawn (coincident with hit_pulse)
- score  out  16  saturating score
- all_dead  out  1  high when alive_mask == 0

Behaviour:
- Reset values:
  - alive_mask = 21'h1FFFFF; score = 0; hit_index = 0.
  - hit_pulse = 0; missile_kill = 0; all_dead = 0.
  - State = ARMED; internal col/row/remainder registers = 0.
- frame_clk handling: two-flop synchronizer, then rising-edge detect, giving frame_edge (one Clk cycle).
- States: ARMED, DIV_X, DIV_Y, CHECK, COMMIT, WAIT_FRAME.
  - ARMED, when enemy_on & missile_on:
    - If DrawX < fleet_x or DrawY < fleet_y -> WAIT_FRAME.
    - Else latch rx = DrawX - fleet_x, ry = DrawY - fleet_y, col = 0, row = 0 -> DIV_X.
  - DIV_X, each cycle:
    - If rx >= COL_PITCH: rx -= COL_PITCH, col += 1.
    - If col reaches 7 -> WAIT_FRAME (discard).
    - If rx < COL_PITCH -> DIV_Y.
  - DIV_Y: same procedure with ry/ROW_PITCH/row; row reaching 3 -> WAIT_FRAME.
  - CHECK:
    - Proceed to COMMIT only if rx < ENEMY_W, ry < ENEMY_H, and alive_mask[row*7+col] == 1.
    - Otherwise -> WAIT_FRAME.
  - COMMIT (one cycle):
    - Clear the mask bit; hit_index = row*7+col.
    - hit_pulse = missile_kill = 1 on the next cycle only.
    - Add the row's points to score, saturating at 16'hFFFF.
    - -> WAIT_FRAME.
  - WAIT_FRAME: ignore overlaps; on frame_edge -> ARMED.
- Once the resolver leaves ARMED, further overlaps in the same frame are ignored. Hence at most one kill per frame.
- Latency from the overlap cycle to hit_pulse: col + row + 5 Clk cycles (e.g. col=0,row=0 -> 5).
  - The fleet origin is latched once at ARMED; later fleet motion does not affect the in-flight resolution.
- frame_edge in a non-WAIT state is ignored; resolution always completes first.
- new_wave:
  - Sets alive_mask to all ones in any state. Score and state are untouched.
  - If coincident with COMMIT, new_wave wins for the mask, but the score is still added and hit_pulse still fires.
- all_dead is registered from alive_mask: it goes high one cycle after the mask reaches zero and drops one cycle after new_wave.
- Reset asserted mid-resolution: everything returns to reset values immediately, with no pending pulse.

Test Plan:
1. fleet=(0,0); overlap at DrawX=80, DrawY=10 -> 6 cycles later: hit_pulse=1, hit_index=1, alive_mask bit1=0, score=10.
2. fleet=(100,20); overlap at (100+3*73+5, 20+2*50+4) -> hit_index=17, score +30, latency 10 cycles.
3. Overlap in the gap at rx=60 (>= ENEMY_W) -> no hit_pulse, mask unchanged, returns to ARMED after the next frame_edge.
4. Two overlaps in one frame, then one more after frame_edge -> exactly two hit_pulses total, one per frame.
5. Kill all 21 (score=420) -> all_dead=1; then new_wave -> mask=1FFFFF, all_dead=0, score stays 420.
6. Preload score near 16'hFFFF and kill a row-2 enemy -> score=FFFF. Assert Reset during DIV_X -> no pulse, all outputs at reset values.

Source files
------------

// File: rtl/enemy_hit_resolver.sv
`default_nettype none
// ============================================================================
// Module   : enemy_hit_resolver
// Purpose  : Resolves which of the 21 fleet enemies (3 rows x 7 columns) a
//            player missile struck. It watches the per-pixel enemy_on and
//            missile_on overlap during the VGA scan. On an overlap it latches
//            the pixel offset from the fleet origin and divides it by the
//            column and row pitch using repeated subtraction, one step per
//            clock. It then checks the remainders against the sprite box and
//            the alive mask. A hit clears the mask bit, fires a one-cycle
//            kill pulse and adds the row's points to a saturating score.
//            At most one kill is resolved per frame.
// Ports    :
//   Clk          in   1   system clock
//   Reset        in   1   asynchronous active-high reset
//   frame_clk    in   1   frame strobe (asynchronous to Clk, synchronized here)
//   new_wave     in   1   pulse: reload alive mask to all ones
//   DrawX/DrawY  in  10   current pixel coordinates
//   enemy_on     in   1   fleet pixel active
//   missile_on   in   1   missile pixel active
//   fleet_x/y    in  10   fleet origin (top-left)
//   alive_mask   out 21   bit row*7+col, 1 = alive
//   hit_pulse    out  1   one-cycle kill event
//   hit_index    out  5   index of the most recent kill
//   missile_kill out  1   one-cycle missile despawn, coincident with hit_pulse
//   score        out 16   saturating score
//   all_dead     out  1   registered (alive_mask == 0)
// Revision : 1.0 - initial release
// ============================================================================
module enemy_hit_resolver #(
    parameter int COL_PITCH = 73,
    parameter int ROW_PITCH = 50,
    parameter int ENEMY_W   = 48,
    parameter int ENEMY_H   = 32,
    parameter int PTS_ROW0  = 10,
    parameter int PTS_ROW1  = 20,
    parameter int PTS_ROW2  = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        new_wave,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        enemy_on,
    input  logic        missile_on,
    input  logic [9:0]  fleet_x,
    input  logic [9:0]  fleet_y,
    output logic [20:0] alive_mask,
    output logic        hit_pulse,
    output logic [4:0]  hit_index,
    output logic        missile_kill,
    output logic [15:0] score,
    output logic        all_dead
);

    localparam logic [9:0]  C_COL_PITCH = 10'(COL_PITCH);
    localparam logic [9:0]  C_ROW_PITCH = 10'(ROW_PITCH);
    localparam logic [9:0]  C_ENEMY_W   = 10'(ENEMY_W);
    localparam logic [9:0]  C_ENEMY_H   = 10'(ENEMY_H);
    localparam logic [15:0] C_PTS_ROW0  = 16'(PTS_ROW0);
    localparam logic [15:0] C_PTS_ROW1  = 16'(PTS_ROW1);
    localparam logic [15:0] C_PTS_ROW2  = 16'(PTS_ROW2);

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_DIV_X      = 3'd1,
        ST_DIV_Y      = 3'd2,
        ST_CHECK      = 3'd3,
        ST_COMMIT     = 3'd4,
        ST_WAIT_FRAME = 3'd5
    } state_t;

    state_t       state_q;
    logic [9:0]   rx_q;
    logic [9:0]   ry_q;
    logic [2:0]   col_q;
    logic [1:0]   row_q;
    logic [20:0]  alive_q;
    logic [15:0]  score_q;
    logic [4:0]   hit_index_q;
    logic         hit_pulse_q;
    logic         all_dead_q;
    logic         fsync1_q;
    logic         fsync2_q;
    logic         fprev_q;

    logic         frame_edge_d;
    logic [2:0]   col_inc_d;
    logic [1:0]   row_inc_d;
    logic [4:0]   idx_d;
    logic [15:0]  pts_d;
    logic [16:0]  score_sum_d;
    logic [15:0]  score_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    always_comb begin
        frame_edge_d = fsync2_q & ~fprev_q;
        col_inc_d    = col_q + 3'd1;
        row_inc_d    = row_q + 2'd1;
        idx_d        = (5'(row_q) * 5'd7) + 5'(col_q);

        case (row_q)
            2'd0:    pts_d = C_PTS_ROW0;
            2'd1:    pts_d = C_PTS_ROW1;
            default: pts_d = C_PTS_ROW2;
        endcase

        // A carry out of bit 15 means the score would wrap; clamp instead.
        score_sum_d = {1'b0, score_q} + {1'b0, pts_d};
        score_d     = score_sum_d[16] ? 16'hFFFF : score_sum_d[15:0];
    end

    // ------------------------------------------------------------------
    // Resolver FSM, synchronizer and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_ARMED;
            rx_q        <= '0;
            ry_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            alive_q     <= 21'h1FFFFF;
            score_q     <= '0;
            hit_index_q <= '0;
            hit_pulse_q <= 1'b0;
            all_dead_q  <= 1'b0;
            fsync1_q    <= 1'b0;
            fsync2_q    <= 1'b0;
            fprev_q     <= 1'b0;
        end else begin
            fsync1_q    <= frame_clk;
            fsync2_q    <= fsync1_q;
            fprev_q     <= fsync2_q;
            hit_pulse_q <= 1'b0;
            all_dead_q  <= (alive_q == 21'd0);

            case (state_q)
                ST_ARMED: begin
                    if (enemy_on && missile_on) begin
                        // Pixels left of or above the origin cannot belong
                        // to any enemy; give up for this frame.
                        if ((DrawX < fleet_x) || (DrawY < fleet_y)) begin
                            state_q <= ST_WAIT_FRAME;
                        end else begin
                            // Origin is captured here so fleet motion during
                            // the division cannot disturb the result.
                            rx_q    <= DrawX - fleet_x;
                            ry_q    <= DrawY - fleet_y;
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= ST_DIV_X;
                        end
                    end
                end

                ST_DIV_X: begin
                    if (rx_q >= C_COL_PITCH) begin
                        rx_q  <= rx_q - C_COL_PITCH;
                        col_q <= col_inc_d;
                        // Right of the seventh column: not a fleet slot.
                        if (col_inc_d == 3'd7) begin
                            state_q <= ST_WAIT_FRAME;
                        end
                    end else begin
                        state_q <= ST_DIV_Y;
                    end
                end

                ST_DIV_Y: begin
                    if (ry_q >= C_ROW_PITCH) begin
                        ry_q  <= ry_q - C_ROW_PITCH;
                        row_q <= row_inc_d;
                        if (row_inc_d == 2'd3) begin
                            state_q <= ST_WAIT_FRAME;
                        end
                    end else begin
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    // Remainder outside the sprite box means the overlap
                    // fell in the gap between enemies.
                    if ((rx_q < C_ENEMY_W) && (ry_q < C_ENEMY_H) && alive_q[idx_d]) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        state_q <= ST_WAIT_FRAME;
                    end
                end

                ST_COMMIT: begin
                    alive_q[idx_d] <= 1'b0;
                    hit_index_q    <= idx_d;
                    hit_pulse_q    <= 1'b1;
                    score_q        <= score_d;
                    state_q        <= ST_WAIT_FRAME;
                end

                ST_WAIT_FRAME: begin
                    if (frame_edge_d) begin
                        state_q <= ST_ARMED;
                    end
                end

                default: begin
                    state_q <= ST_ARMED;
                end
            endcase

            // Placed after the FSM so a wave reload overrides a kill that
            // commits in the same cycle.
            if (new_wave) begin
                alive_q <= 21'h1FFFFF;
            end
        end
    end

    assign alive_mask   = alive_q;
    assign hit_pulse    = hit_pulse_q;
    assign missile_kill = hit_pulse_q;
    assign hit_index    = hit_index_q;
    assign score        = score_q;
    assign all_dead     = all_dead_q;

endmodule
`default_nettype wire
